// File: rtl/dma_pkg.sv
// Shared types and constants for the single-channel DMA engine.
//   MEM_SIZE_*  : bus size codes (BYTE/RESR are never driven by the channel)
//   addr_ctrl_t : per-side address stepping mode
//   dma_state_t : channel FSM states
//   align_addr  : clears the low address bits a unit of the given width may not use
package dma_pkg;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
   localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
   localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
   localparam logic [1:0] MEM_SIZE_RESR = 2'b11;

   typedef enum logic [1:0] {
      INC   = 2'b00,
      DEC   = 2'b01,
      FIXED = 2'b10
   } addr_ctrl_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_RD_A = 3'd2,
      ST_WR_A = 3'd3,
      ST_WR_D = 3'd4,
      ST_DONE = 3'd5
   } dma_state_t;

   function automatic logic [31:0] align_addr(input logic [31:0] a, input logic word);
      return word ? {a[31:2], 2'b00} : {a[31:1], 1'b0};
   endfunction

endpackage

// File: rtl/dma_addr_step.sv
// Combinational next-address calculation for one side of the channel.
//   addr_i : current (aligned) address
//   ctrl_i : INC / DEC / FIXED; the unused encoding behaves as FIXED
//   word_i : 1 = 4-byte stride, 0 = 2-byte stride
//   addr_o : next address, 32-bit modulo
module dma_addr_step
   import dma_pkg::*;
(
   input  logic [31:0] addr_i,
   input  addr_ctrl_t  ctrl_i,
   input  logic        word_i,
   output logic [31:0] addr_o
);

   logic [31:0] stride;

   always_comb begin
      stride = word_i ? 32'd4 : 32'd2;
      case (ctrl_i)
         INC:     addr_o = addr_i + stride;
         DEC:     addr_o = addr_i - stride;
         default: addr_o = addr_i;
      endcase
   end

endmodule

// File: rtl/dma_channel.sv
// Single-channel DMA engine: copies COUNT halfword/word units from SRC to DST
// with a read-then-write sequence on the memory bus, arbitrating via bus_req/bus_gnt.
//   clk, rst                : clock, async active-high reset
//   start, src_addr, dst_addr, count, word, src_ctrl, dst_ctrl : job setup
//   busy, done, error       : job status (done/error are one-cycle pulses)
//   bus_req, bus_gnt        : arbitration
//   addr, wdata, size, write, rdata, pause, abort : memory bus
//
// state   | meaning
// IDLE    | waiting for start
// REQ     | bus requested, bus idle, waiting for grant
// RD_A    | read address phase (addr = src)
// WR_A    | read data returns, write address phase (addr = dst)
// WR_D    | write data phase, advance addresses and count
// DONE    | one-cycle completion pulse
module dma_channel
   import dma_pkg::*;
#(
   parameter int          CNT_W    = 14,
   parameter logic [31:0] RST_ADDR = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [CNT_W-1:0] count,
   input  logic             word,
   input  addr_ctrl_t       src_ctrl,
   input  addr_ctrl_t       dst_ctrl,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic             bus_req,
   input  logic             bus_gnt,
   output logic [31:0]      addr,
   output logic [31:0]      wdata,
   output logic [1:0]       size,
   output logic             write,
   input  logic [31:0]      rdata,
   input  logic             pause,
   input  logic             abort
);

   dma_state_t       state_q;
   logic [31:0]      src_q, dst_q, src_d, dst_d;
   logic [CNT_W-1:0] cnt_q;
   logic             word_q;
   addr_ctrl_t       src_ctrl_q, dst_ctrl_q;
   logic             busy_q, done_q, error_q, bus_req_q, write_q;
   logic [31:0]      addr_q, wdata_q;
   logic [1:0]       size_q;
   logic [31:0]      unit;
   logic             abort_hit;

   dma_addr_step u_src_step (.addr_i(src_q), .ctrl_i(src_ctrl_q), .word_i(word_q), .addr_o(src_d));
   dma_addr_step u_dst_step (.addr_i(dst_q), .ctrl_i(dst_ctrl_q), .word_i(word_q), .addr_o(dst_d));

   // Halfword lane is chosen by the read address, which is still src_q during WR_A.
   // The halfword is replicated so the memory byte-enables can pick either lane.
   always_comb begin
      unit = rdata;
      if (!word_q) unit = src_q[1] ? {rdata[31:16], rdata[31:16]} : {rdata[15:0], rdata[15:0]};
   end

   assign abort_hit = abort && (state_q == ST_WR_A || state_q == ST_WR_D);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         cnt_q      <= '0;
         word_q     <= 1'b0;
         src_ctrl_q <= INC;
         dst_ctrl_q <= INC;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         bus_req_q  <= 1'b0;
         write_q    <= 1'b0;
         addr_q     <= RST_ADDR;
         wdata_q    <= '0;
         size_q     <= MEM_SIZE_WORD;
      end else if (!pause) begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         if (abort_hit) begin
            state_q   <= ST_IDLE;
            error_q   <= 1'b1;
            busy_q    <= 1'b0;
            bus_req_q <= 1'b0;
            addr_q    <= RST_ADDR;
            write_q   <= 1'b0;
            wdata_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: if (start) begin
                  state_q    <= ST_REQ;
                  busy_q     <= 1'b1;
                  bus_req_q  <= 1'b1;
                  src_q      <= align_addr(src_addr, word);
                  dst_q      <= align_addr(dst_addr, word);
                  cnt_q      <= count;
                  word_q     <= word;
                  src_ctrl_q <= src_ctrl;
                  dst_ctrl_q <= dst_ctrl;
                  size_q     <= word ? MEM_SIZE_WORD : MEM_SIZE_HALF;
               end
               ST_REQ: if (bus_gnt) begin
                  state_q <= ST_RD_A;
                  addr_q  <= src_q;
                  write_q <= 1'b0;
               end
               ST_RD_A: begin
                  state_q <= ST_WR_A;
                  addr_q  <= dst_q;
                  write_q <= 1'b1;
               end
               ST_WR_A: begin
                  state_q <= ST_WR_D;
                  addr_q  <= RST_ADDR;
                  write_q <= 1'b0;
                  wdata_q <= unit;
               end
               ST_WR_D: begin
                  src_q   <= src_d;
                  dst_q   <= dst_d;
                  cnt_q   <= cnt_q - 1'b1;
                  wdata_q <= '0;
                  // count of 0 wraps through all ones, giving 2**CNT_W units
                  if (cnt_q == CNT_W'(1)) begin
                     state_q   <= ST_DONE;
                     done_q    <= 1'b1;
                     busy_q    <= 1'b0;
                     bus_req_q <= 1'b0;
                  end else if (bus_gnt) begin
                     state_q <= ST_RD_A;
                     addr_q  <= src_d;
                  end else begin
                     state_q <= ST_REQ;
                  end
               end
               ST_DONE: state_q <= ST_IDLE;
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign error   = error_q;
   assign bus_req = bus_req_q;
   assign addr    = addr_q;
   assign wdata   = wdata_q;
   assign size    = size_q;
   assign write   = write_q;

endmodule
